// File: rtl/mem_stim_gen_chk.sv
// Memory-port traffic generator with strided wrapping addresses,
// pipelined reads and in-order readback checking.
module mem_stim_gen_chk #(
  parameter int          AddrWidth       = 32,
  parameter int          DataWidth       = 64,
  parameter int          NumTransactions = 16,
  parameter int          RegionStart     = 0,
  parameter int          RegionBytes     = 4096,
  parameter int          Stride          = 8,
  parameter int          MaxOutstanding  = 4,
  parameter logic [31:0] Seed            = 32'h1234_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            err_cnt_o,
  output logic [15:0]            first_err_idx_o,
  output logic                   proto_err_o
);

  localparam int Lanes = DataWidth / 32;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] rsp_q, rsp_d;
  logic [15:0] err_q, err_d;
  logic [15:0] first_q, first_d;
  logic [3:0]  out_q, out_d;
  logic [1:0]  mode_q, mode_d;
  logic        proto_q, proto_d;

  logic last, rd_req, req, we, rd_hs;
  logic rv_ok, rv_bad, mis;

  function automatic logic [DataWidth-1:0] pattern(
    input logic [15:0] k
  );
    logic [DataWidth-1:0] p;
    p = '0;
    for (int j = 0; j < Lanes; j++) begin
      p[j*32 +: 32] = Seed + 32'(k) * 32'(Lanes) + 32'(j);
    end
    return p;
  endfunction

  function automatic logic [AddrWidth-1:0] addr_of(
    input logic [15:0] k
  );
    logic [AddrWidth-1:0] off;
    off = AddrWidth'(k) * AddrWidth'(Stride);
    return AddrWidth'(RegionStart)
         + (off & AddrWidth'(RegionBytes - 1));
  endfunction

  assign last   = idx_q == 16'(NumTransactions - 1);
  assign rd_req = (state_q == READ)
               && (idx_q < 16'(NumTransactions))
               && (out_q < 4'(MaxOutstanding));
  assign we     = state_q == WRITE;
  assign req    = we || rd_req;
  assign rd_hs  = rd_req && mem_gnt_i;
  assign rv_ok  = mem_rvalid_i && (out_q != 4'd0);
  assign rv_bad = mem_rvalid_i && (out_q == 4'd0);
  assign mis    = rv_ok && mode_q[1]
               && (mem_rdata_i != pattern(rsp_q));

  // Outputs are zeroed when idle so reset values hold
  assign mem_req_o       = req;
  assign mem_we_o        = we;
  assign mem_addr_o      = req ? addr_of(idx_q) : '0;
  assign mem_wdata_o     = we ? pattern(idx_q) : '0;
  assign mem_be_o        = we ? '1 : '0;
  assign busy_o          = !(state_q == IDLE || state_q == DONE);
  assign done_o          = state_q == DONE;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = first_q;
  assign proto_err_o     = proto_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    first_d = first_q;
    mode_d  = mode_q;
    proto_d = proto_q;
    out_d   = out_q + {3'b0, rd_hs} - {3'b0, rv_ok};
    if (rv_ok) rsp_d = rsp_q + 16'd1;
    if (mis) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (first_q == 16'hFFFF) first_d = rsp_q;
    end
    if (rv_bad) proto_d = 1'b1;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          mode_d  = mode_i;
          idx_d   = '0;
          rsp_d   = '0;
          err_d   = '0;
          first_d = 16'hFFFF;
          proto_d = 1'b0;
          state_d = (mode_i == 2'd1) ? READ : WRITE;
        end
      end
      WRITE: begin
        if (mem_gnt_i) begin
          if (last) begin
            idx_d   = '0;
            state_d = mode_q[1] ? READ : DONE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      READ: begin
        if (rd_hs) begin
          if (last) state_d = DRAIN;
          else      idx_d   = idx_q + 16'd1;
        end
      end
      DRAIN: begin
        if (out_d == 4'd0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rsp_q   <= '0;
      err_q   <= '0;
      first_q <= 16'hFFFF;
      out_q   <= '0;
      mode_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      first_q <= first_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      proto_q <= proto_d;
    end
  end

endmodule

// File: tb/tb_mem_stim_gen_chk.sv
// Bench for mem_stim_gen_chk: reactive memory model with a
// per-cycle reference check plus directed end-of-run checks.
module tb_mem_stim_gen_chk;

  localparam logic [31:0] SEED = 32'h1234_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        mem_req, mem_we;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy, done, proto;
  logic [15:0] err_cnt, first_idx;

  logic        w_start = 1'b0;
  logic        w_gnt = 1'b1;
  logic        w_req, w_we, w_busy, w_done, w_proto;
  logic [31:0] w_addr;
  logic [7:0]  w_be;
  logic [63:0] w_wdata;
  logic [15:0] w_err, w_first;

  always #5 clk = ~clk;

  mem_stim_gen_chk u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .start_i(start_i), .mode_i(mode_i),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .done_o(done),
    .err_cnt_o(err_cnt), .first_err_idx_o(first_idx),
    .proto_err_o(proto)
  );

  mem_stim_gen_chk #(
    .NumTransactions(8), .RegionBytes(64), .Stride(24)
  ) u_wrap (
    .clk_i(clk), .rst_ni(rst_ni),
    .start_i(w_start), .mode_i(2'd0),
    .mem_req_o(w_req), .mem_gnt_i(w_gnt),
    .mem_addr_o(w_addr), .mem_we_o(w_we),
    .mem_be_o(w_be), .mem_wdata_o(w_wdata),
    .mem_rvalid_i(1'b0), .mem_rdata_i(64'd0),
    .busy_o(w_busy), .done_o(w_done),
    .err_cnt_o(w_err), .first_err_idx_o(w_first),
    .proto_err_o(w_proto)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    return 32'((k * 8) % 4096);
  endfunction

  function automatic logic [63:0] exp_pat(input int k);
    logic [31:0] lo;
    lo = SEED + 32'(2 * k);
    return {lo + 32'd1, lo};
  endfunction

  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  logic [63:0] mem [512];
  rsp_t        rq[$];
  int          lat = 1;
  bit          rnd_gnt = 0;
  bit          corrupt = 0;
  bit          inject = 0;
  int          cyc = 0;
  int          wk = 0, rk = 0, mout = 0, nrsp = 0, max_out = 0;
  logic        prev_req = 0, prev_gnt = 0, prev_we = 0, prev_rv = 0;
  logic [31:0] prev_addr = '0, wa15 = '0;
  logic [63:0] prev_wdata = '0, wd5 = '0;

  // Memory responder and per-cycle reference compare
  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      rq.delete();
      mem_gnt = 0; mem_rvalid = 0;
      wk = 0; rk = 0; mout = 0; nrsp = 0;
      prev_req = 0; prev_gnt = 0; prev_rv = 0;
    end else begin
      if (prev_req && prev_gnt) begin
        if (prev_we) begin
          if (wk == 5) wd5 = prev_wdata;
          if (wk == 15) wa15 = prev_addr;
          wk++;
        end else begin
          rk++; mout++;
        end
      end
      if (prev_rv) begin mout--; nrsp++; end
      if (start_i) begin wk = 0; rk = 0; nrsp = 0; end
      if (mout > max_out) max_out = mout;
      check("outstanding_max", 64'(mout <= 4), 1);
      if (prev_req && !prev_gnt) begin
        check("req_held", 64'(mem_req), 1);
        check("addr_stable", 64'(mem_addr), 64'(prev_addr));
        check("we_stable", 64'(mem_we), 64'(prev_we));
        check("wdata_stable", mem_wdata, prev_wdata);
      end
      if (mem_req) begin
        if (mem_we) begin
          check("waddr", 64'(mem_addr), 64'(exp_addr(wk)));
          check("wdata", mem_wdata, exp_pat(wk));
          check("wbe", 64'(mem_be), 64'hFF);
        end else begin
          check("raddr", 64'(mem_addr), 64'(exp_addr(rk)));
          check("rbe", 64'(mem_be), 0);
          check("rd_room", 64'(mout < 4), 1);
        end
      end
      prev_rv = 0;
      mem_rvalid = 0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rvalid = 1;
        mem_rdata = rq[0].data;
        void'(rq.pop_front());
        prev_rv = 1;
      end else if (inject) begin
        mem_rvalid = 1;
        mem_rdata = '1;
      end
      mem_gnt = rnd_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr[11:3]] = mem_wdata;
        end else begin
          rsp_t r;
          r.due  = cyc + lat;
          r.data = mem[mem_addr[11:3]];
          if (corrupt && mem_addr == 32'h28) r.data[0] = ~r.data[0];
          rq.push_back(r);
        end
      end
      prev_req = mem_req; prev_gnt = mem_gnt; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  end

  logic [31:0] wq[$];
  always @(negedge clk) begin
    if (w_req && w_gnt) wq.push_back(w_addr);
  end

  task automatic do_start(input logic [1:0] m);
    @(posedge clk); #1;
    mode_i = m; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 2000) begin
      @(negedge clk); #1;
      cnt++;
    end
    check("done_reached", 64'(done), 1);
  endtask

  logic [31:0] wexp [8];
  int cnt;

  initial begin
    wexp = '{32'h00, 32'h18, 32'h30, 32'h08,
             32'h20, 32'h38, 32'h10, 32'h28};
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(mem_req), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err_cnt), 0);
    check("rst_first", 64'(first_idx), 64'hFFFF);
    check("rst_proto", 64'(proto), 0);
    rst_ni = 1;

    @(posedge clk); #1 w_start = 1;
    @(posedge clk); #1 w_start = 0;
    repeat (12) @(negedge clk);
    check("wrap_count", 64'(wq.size()), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      check($sformatf("wrap_addr%0d", i), 64'(wq[i]), 64'(wexp[i]));
    check("wrap_done", 64'(w_done), 1);
    check("wrap_busy", 64'(w_busy), 0);

    lat = 1;
    do_start(2'd2);
    wait_done(cnt);
    check("done_cycle_ok", 64'((cnt + 1) >= 34 && (cnt + 1) <= 36), 1);
    check("a_err", 64'(err_cnt), 0);
    check("a_first", 64'(first_idx), 64'hFFFF);
    check("a_nrsp", 64'(nrsp), 16);
    check("a_addr15", 64'(wa15), 64'h78);
    check("a_wdata5", wd5, {32'h1234_000B, 32'h1234_000A});
    check("a_busy", 64'(busy), 0);

    corrupt = 1;
    do_start(2'd2);
    wait_done(cnt);
    check("b_err", 64'(err_cnt), 1);
    check("b_first", 64'(first_idx), 5);
    corrupt = 0;
    do_start(2'd2);
    check("b_clr_err", 64'(err_cnt), 0);
    check("b_clr_first", 64'(first_idx), 64'hFFFF);
    check("b_clr_done", 64'(done), 0);
    wait_done(cnt);
    check("b2_err", 64'(err_cnt), 0);

    lat = 6; rnd_gnt = 1; max_out = 0;
    do_start(2'd2);
    wait_done(cnt);
    rnd_gnt = 0;
    check("c_err", 64'(err_cnt), 0);
    check("c_first", 64'(first_idx), 64'hFFFF);
    check("c_nrsp", 64'(nrsp), 16);
    check("c_maxout", 64'(max_out <= 4), 1);

    do_start(2'd1);
    cnt = 0;
    while (mout != 3 && cnt < 100) begin
      @(negedge clk); #1;
      cnt++;
    end
    check("d_out3", 64'(mout), 3);
    rst_ni = 0;
    #1;
    check("d_req", 64'(mem_req), 0);
    check("d_addr", 64'(mem_addr), 0);
    check("d_be", 64'(mem_be), 0);
    check("d_wdata", mem_wdata, 0);
    check("d_busy", 64'(busy), 0);
    check("d_first", 64'(first_idx), 64'hFFFF);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    do_start(2'd1);
    wait_done(cnt);
    check("d_proto", 64'(proto), 0);
    check("d_nrsp", 64'(nrsp), 16);

    @(posedge clk); #1 inject = 1;
    @(posedge clk); #1 inject = 0;
    @(negedge clk); #1;
    check("e_proto", 64'(proto), 1);
    check("e_err", 64'(err_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
